inert_spi_seq: RTL and testbench

INERT_SPI_SEQ -- requirements
Module: inert_spi_seq

---
 rtl/inert_spi_seq.sv | 202 ++++++++++++++++++++
 tb/tb_inert_spi_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_spi_seq.sv
// rtl/inert_spi_seq.sv - iNEMO SPI sequencer: config writes after power-up delay, 10-byte readout per data-ready edge
// Optional transaction timeout with sticky err when INERT_SEQ_TMO_EN is defined.
module inert_spi_seq #(
  parameter logic [15:0] INIT_DLY = 16'hFFFF,
  parameter int          TMO_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic [15:0] AX,
  output logic [15:0] AY,
  output logic        vld,
  output logic        init_done,
  output logic        err
);

  typedef enum logic [2:0] {
    DLY,
    INIT_SND,
    INIT_WT,
    IDLE,
    RD_SND,
    RD_WT,
    VLD
  } state_t;

  localparam logic [15:0] DLY_LAST = INIT_DLY - 16'd1;
  localparam logic [6:0]  RD_BASE  = 7'h22;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] dly_cnt;
  logic [3:0]  idx;
  logic        int_s1;
  logic        int_s2;
  logic        int_s3;
  logic        int_rise;
  logic        pending;
  logic [71:0] shadow;
  logic [79:0] sample;
  logic        tmo_hit;
  logic [7:0]  resp_hi_unused;

  function automatic logic [15:0] init_word(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1053;
      2'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_word(input logic [3:0] i);
    return {1'b1, RD_BASE + {3'b000, i}, 8'h00};
  endfunction

  assign int_rise       = int_s2 & ~int_s3;
  assign resp_hi_unused = resp[15:8];
  // Bytes arrive low register first; the tenth byte is still on resp when the set completes.
  assign sample         = {resp[7:0], shadow};

  assign snd = (state == INIT_SND) || (state == RD_SND);
  assign vld = (state == VLD);

  always_comb begin
    state_nxt = state;
    case (state)
      DLY:      if (dly_cnt == DLY_LAST) state_nxt = INIT_SND;
      INIT_SND: state_nxt = INIT_WT;
      INIT_WT: begin
        if (done)         state_nxt = (idx == 4'd3) ? IDLE : INIT_SND;
        else if (tmo_hit) state_nxt = DLY;
      end
      IDLE:     if (pending) state_nxt = RD_SND;
      RD_SND:   state_nxt = RD_WT;
      RD_WT: begin
        if (done)         state_nxt = (idx == 4'd9) ? VLD : RD_SND;
        else if (tmo_hit) state_nxt = IDLE;
      end
      VLD:      state_nxt = IDLE;
      default:  state_nxt = DLY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= DLY;
      dly_cnt   <= 16'd0;
      idx       <= 4'd0;
      int_s1    <= 1'b0;
      int_s2    <= 1'b0;
      int_s3    <= 1'b0;
      pending   <= 1'b0;
      shadow    <= 72'd0;
      cmd       <= 16'd0;
      ptch_rt   <= 16'd0;
      roll_rt   <= 16'd0;
      yaw_rt    <= 16'd0;
      AX        <= 16'd0;
      AY        <= 16'd0;
      init_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      int_s1 <= INT;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
      // An edge landing in the same cycle the read starts must survive the clear.
      pending <= (int_rise && init_done) || (pending && (state != IDLE));

      case (state)
        DLY: begin
          idx <= 4'd0;
          if (dly_cnt == DLY_LAST) begin
            dly_cnt <= 16'd0;
            cmd     <= init_word(2'd0);
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end
        INIT_WT: begin
          if (done) begin
            if (idx == 4'd3) begin
              init_done <= 1'b1;
              idx       <= 4'd0;
            end else begin
              idx <= idx + 4'd1;
              cmd <= init_word(idx[1:0] + 2'd1);
            end
          end else if (tmo_hit) begin
            idx <= 4'd0;
          end
        end
        IDLE: begin
          if (pending) begin
            idx    <= 4'd0;
            shadow <= 72'd0;
            cmd    <= rd_word(4'd0);
          end
        end
        RD_WT: begin
          if (done) begin
            if (idx == 4'd9) begin
              ptch_rt <= sample[15:0];
              roll_rt <= sample[31:16];
              yaw_rt  <= sample[47:32];
              AX      <= sample[63:48];
              AY      <= sample[79:64];
              shadow  <= 72'd0;
              idx     <= 4'd0;
            end else begin
              shadow <= {resp[7:0], shadow[71:8]};
              idx    <= idx + 4'd1;
              cmd    <= rd_word(idx + 4'd1);
            end
          end else if (tmo_hit) begin
            shadow <= 72'd0;
            idx    <= 4'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INERT_SEQ_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt;

  // tmo_cnt holds the number of cycles elapsed since the snd cycle.
  assign tmo_hit = ((state == INIT_WT) || (state == RD_WT)) && !done &&
                   (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (snd)
        tmo_cnt <= TW'(1);
      else if (((state == INIT_WT) || (state == RD_WT)) && !done)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        err <= 1'b1;
    end
  end
`else
  localparam int tmo_cyc_unused = TMO_CYC;

  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_inert_spi_seq.sv
// tb/tb_inert_spi_seq.sv - self-checking bench for inert_spi_seq
// Compile with INERT_SEQ_TMO_EN to include the withheld-done scenario.
module tb_inert_spi_seq;

  localparam logic [15:0] DLY = 16'd16;
  localparam int          TMO = 64;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        int_line = 1'b0;
  logic        done     = 1'b0;
  logic [15:0] resp     = 16'h0000;
  logic        snd;
  logic        vld;
  logic        init_done;
  logic        err;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] roll_rt;
  logic [15:0] yaw_rt;
  logic [15:0] ax;
  logic [15:0] ay;

  int n_cmp        = 0;
  int n_bad        = 0;
  int vld_cnt      = 0;
  int snd_overlap  = 0;
  int cmd_unstable = 0;
  int data_glitch  = 0;
  bit directed     = 1'b0;
  bit hold_done    = 1'b0;
  bit spur_req     = 1'b0;

  logic [15:0] cmd_log[$];
  logic [7:0]  rd_bytes[$];
  logic [15:0] init_seq[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

  always #5 clk = ~clk;

  inert_spi_seq #(
    .INIT_DLY(DLY),
    .TMO_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (int_line),
    .snd      (snd),
    .cmd      (cmd),
    .done     (done),
    .resp     (resp),
    .ptch_rt  (ptch_rt),
    .roll_rt  (roll_rt),
    .yaw_rt   (yaw_rt),
    .AX       (ax),
    .AY       (ay),
    .vld      (vld),
    .init_done(init_done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI monarch model: random latency, one byte per read, logs every command issued.
  initial begin : responder
    logic [15:0] cur;
    logic [7:0]  b;
    int          wait_left;
    bit          busy;
    cur = '0;
    b = '0;
    wait_left = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (snd === 1'b1) snd_overlap++;
        if (cmd !== cur) cmd_unstable++;
        if (wait_left == 0) begin
          if (cur[15] && directed) b = {1'b0, cur[14:8] - 7'h21};
          else b = 8'($urandom);
          if (cur[15]) rd_bytes.push_back(b);
          resp = {8'($urandom), b};
          done = 1'b1;
          busy = 1'b0;
        end else begin
          wait_left--;
        end
      end else if (snd === 1'b1) begin
        cur = cmd;
        cmd_log.push_back(cmd);
        busy = !hold_done;
        wait_left = $urandom_range(0, 3);
      end else if (spur_req) begin
        resp = 16'h00EE;
        done = 1'b1;
        spur_req = 1'b0;
      end
    end
  end

  // Reference: each vld presents the last ten read bytes as little-endian word pairs.
  initial begin : vld_mon
    int t;
    logic [79:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (vld === 1'b1) begin
        vld_cnt++;
        if (rd_bytes.size() >= 10) begin
          t = rd_bytes.size() - 10;
          check("ptch_rt", ptch_rt, {rd_bytes[t+1], rd_bytes[t]});
          check("roll_rt", roll_rt, {rd_bytes[t+3], rd_bytes[t+2]});
          check("yaw_rt",  yaw_rt,  {rd_bytes[t+5], rd_bytes[t+4]});
          check("AX",      ax,      {rd_bytes[t+7], rd_bytes[t+6]});
          check("AY",      ay,      {rd_bytes[t+9], rd_bytes[t+8]});
        end
      end
      if (!rst_n || vld === 1'b1) prev = {ay, ax, yaw_rt, roll_rt, ptch_rt};
      else if ({ay, ax, yaw_rt, roll_rt, ptch_rt} !== prev) data_glitch++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_int();
    @(negedge clk);
    #($urandom_range(1, 8));
    int_line = 1'b1;
    repeat (3) @(negedge clk);
    int_line = 1'b0;
  endtask

  task automatic wait_init();
    int g;
    g = 0;
    while (init_done !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("init_done", init_done, 1'b1);
    check("init_count", cmd_log.size(), 4);
    for (int i = 0; i < 4 && i < cmd_log.size(); i++)
      check("init_cmd", cmd_log[i], init_seq[i]);
  endtask

  task automatic run_reads(input bit dir, input int second_at);
    int base_v;
    int nexp;
    int g;
    directed = dir;
    base_v = vld_cnt;
    nexp = (second_at >= 0) ? 2 : 1;
    cmd_log.delete();
    pulse_int();
    if (second_at >= 0) begin
      g = 0;
      while (cmd_log.size() <= second_at && g < 1000) begin
        @(negedge clk);
        g++;
      end
      pulse_int();
    end
    g = 0;
    while (vld_cnt < base_v + nexp && g < 2000) begin
      @(negedge clk);
      g++;
    end
    repeat (60) @(negedge clk);
    check("vld_pulses", vld_cnt - base_v, nexp);
    check("read_count", cmd_log.size(), 10 * nexp);
    for (int i = 0; i < cmd_log.size(); i++)
      check("read_cmd", cmd_log[i], {1'b1, 7'h22 + 7'(i % 10), 8'h00});
  endtask

  initial begin : main
    int          cyc;
    int          base_v;
    int          base_n;
    bit          bad;
    logic [15:0] saved;

    repeat (3) @(negedge clk);
    check("rst_snd", snd, 1'b0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_vld", vld, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data", {ptch_rt, roll_rt}, 32'h0);
    check("rst_data2", {yaw_rt, ax, ay}, 48'h0);

    rst_n = 1'b1;
    cyc = 0;
    while (snd !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("first_snd_cycle", cyc, 16);
    check("first_cmd", cmd, 16'h0D02);

    // Data-ready edge during configuration must be ignored.
    pulse_int();
    wait_init();
    repeat (40) @(negedge clk);
    check("no_read_before_init", cmd_log.size(), 4);
    check("no_vld_before_init", vld_cnt, 0);

    run_reads(1'b1, -1);
    check("dir_ptch", ptch_rt, 16'h0201);
    check("dir_AY", ay, 16'h0A09);

    run_reads(1'b1, 4);

    base_v = vld_cnt;
    base_n = cmd_log.size();
    saved = ptch_rt;
    spur_req = 1'b1;
    repeat (20) @(negedge clk);
    check("spur_consumed", spur_req, 1'b0);
    check("spur_no_snd", cmd_log.size(), base_n);
    check("spur_no_vld", vld_cnt, base_v);
    check("spur_data_held", ptch_rt, saved);

    for (int k = 0; k < 4; k++)
      run_reads(1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : -1);

    // Reset in the middle of read index 6.
    base_v = vld_cnt;
    cmd_log.delete();
    directed = 1'b0;
    pulse_int();
    cyc = 0;
    while (cmd_log.size() < 7 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_idx6", cmd_log.size(), 7);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_snd", snd, 1'b0);
    check("mid_rst_vld", vld, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_cmd", cmd, 16'h0000);
    check("mid_rst_data", {ptch_rt, ay}, 32'h0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (snd !== 1'b0 || vld !== 1'b0) bad = 1'b1;
    end
    check("rst_hold_quiet", bad, 1'b0);
    cmd_log.delete();
    rst_n = 1'b1;
    wait_init();
    check("rst_no_vld", vld_cnt, base_v);

    run_reads(1'b0, -1);

`ifdef INERT_SEQ_TMO_EN
    hold_done = 1'b1;
    base_v = vld_cnt;
    cmd_log.delete();
    @(negedge clk);
    int_line = 1'b1;
    cyc = 0;
    while (snd !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    int_line = 1'b0;
    cyc = 0;
    while (err !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_cycles", cyc, TMO);
    repeat (30) @(negedge clk);
    check("tmo_no_vld", vld_cnt, base_v);
    check("tmo_idle", cmd_log.size(), 1);
    hold_done = 1'b0;
    run_reads(1'b0, -1);
    check("tmo_err_sticky", err, 1'b1);
`else
    check("err_tied_low", err, 1'b0);
`endif

    check("snd_overlap", snd_overlap, 0);
    check("cmd_stable", cmd_unstable, 0);
    check("data_stable", data_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
